// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - funct_t and the R-type funct codes that touch HI/LO
//   - md_state_t, the sequencer state encoding
//   - magnitude(), two's-complement absolute value for signed operands
// ---------------------------------------------------------------------------
package mult_div_unit_pkg;

    // R-type funct field. Kept as a plain 6-bit type because the core can
    // present any funct value; codes that are not listed here are ignored.
    typedef logic [5:0] funct_t;

    localparam funct_t FUNCT_MFHI  = 6'h10;
    localparam funct_t FUNCT_MTHI  = 6'h11;
    localparam funct_t FUNCT_MFLO  = 6'h12;
    localparam funct_t FUNCT_MTLO  = 6'h13;
    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1A;
    localparam funct_t FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX
    } md_state_t;

    // Counter value of the final (32nd) iteration.
    localparam logic [5:0] MD_LAST_ITER = 6'd31;

    // Absolute value of a signed operand; unsigned operands pass through.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v,
                                              input logic        is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/response bundle between the execute stage and the HI/LO unit.
//   start, fncode, a, b : request from the core (master drives)
//   busy, done          : sequencer status (slave drives)
//   hi, lo              : architectural HI/LO registers (slave drives)
// ---------------------------------------------------------------------------
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        start;
    funct_t      fncode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, fncode, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, fncode, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU plus MTHI/MTLO. Owns the
// architectural HI/LO registers. Multiply is shift-add, divide is restoring
// shift-subtract, one bit per cycle, followed by a sign-fix/commit cycle.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   md     slave modport of mult_div_unit_if:
//            start/fncode/a/b  request, sampled while busy=0
//            busy              operation in flight (33 cycles for MUL/DIV)
//            done              one-cycle pulse after HI/LO commit
//            hi/lo             architectural HI/LO registers
// ---------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  md
);

    md_state_t   state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic        is_div_reg, is_div_next;
    // neg_q: product sign (MUL) or quotient sign (DIV); neg_r: remainder sign
    logic        neg_q_reg, neg_q_next;
    logic        neg_r_reg, neg_r_next;
    // Multiplicand magnitude (MUL) or divisor magnitude (DIV)
    logic [31:0] oper_reg, oper_next;
    // Shared working pair: {acc_hi, acc_lo} for MUL, {rem, q} for DIV
    logic [31:0] work_hi_reg, work_hi_next;
    logic [31:0] work_lo_reg, work_lo_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    // Request decode
    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign op_signed = (md.fncode == FUNCT_MULT) || (md.fncode == FUNCT_DIV);
    assign a_mag     = magnitude(md.a, op_signed);
    assign b_mag     = magnitude(md.b, op_signed);

    // Multiply step: conditional add with carry out, then the 65-bit
    // {carry, acc_hi, acc_lo} shifts right by one.
    logic [32:0] mul_sum;
    assign mul_sum = work_lo_reg[0] ? ({1'b0, work_hi_reg} + {1'b0, oper_reg})
                                    : {1'b0, work_hi_reg};

    // Divide step: {rem, q} shifts left; the 33-bit shifted remainder is
    // {work_hi_reg[31], div_shift}. If its top bit is set it necessarily
    // exceeds any 32-bit divisor and the 32-bit difference is exact, so the
    // 33-bit trial subtract reduces to "top bit OR no borrow".
    logic [31:0] div_shift;
    logic [31:0] div_diff;
    logic        div_borrow;
    logic        div_fits;

    assign div_shift              = {work_hi_reg[30:0], work_lo_reg[31]};
    assign {div_borrow, div_diff} = {1'b0, div_shift} - {1'b0, oper_reg};
    assign div_fits               = work_hi_reg[31] | ~div_borrow;

    // Commit values
    logic [63:0] product;
    logic [63:0] product_fixed;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;

    assign product       = {work_hi_reg, work_lo_reg};
    assign product_fixed = neg_q_reg ? (64'd0 - product) : product;
    assign quot_fixed    = neg_q_reg ? (32'd0 - work_lo_reg) : work_lo_reg;
    assign rem_fixed     = neg_r_reg ? (32'd0 - work_hi_reg) : work_hi_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        is_div_next  = is_div_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        oper_next    = oper_reg;
        work_hi_next = work_hi_reg;
        work_lo_next = work_lo_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            MD_IDLE: begin
                if (md.start) begin
                    case (md.fncode)
                        FUNCT_MULT, FUNCT_MULTU: begin
                            state_next   = MD_MUL;
                            busy_next    = 1'b1;
                            is_div_next  = 1'b0;
                            neg_q_next   = op_signed & (md.a[31] ^ md.b[31]);
                            neg_r_next   = 1'b0;
                            oper_next    = a_mag;
                            work_hi_next = 32'd0;
                            work_lo_next = b_mag;
                            cnt_next     = 6'd0;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            state_next   = MD_DIV;
                            busy_next    = 1'b1;
                            is_div_next  = 1'b1;
                            neg_q_next   = op_signed & (md.a[31] ^ md.b[31]);
                            neg_r_next   = op_signed & md.a[31];
                            oper_next    = b_mag;
                            work_hi_next = 32'd0;
                            work_lo_next = a_mag;
                            cnt_next     = 6'd0;
                        end
                        FUNCT_MTHI: hi_next = md.a;
                        FUNCT_MTLO: lo_next = md.a;
                        default: ;
                    endcase
                end
            end

            MD_MUL: begin
                work_hi_next = mul_sum[32:1];
                work_lo_next = {mul_sum[0], work_lo_reg[31:1]};
                cnt_next     = cnt_reg + 6'd1;
                if (cnt_reg == MD_LAST_ITER) begin
                    state_next = MD_FIX;
                end
            end

            MD_DIV: begin
                // A zero divisor always "fits", giving q=all ones, rem=dividend.
                work_hi_next = div_fits ? div_diff : div_shift;
                work_lo_next = {work_lo_reg[30:0], div_fits};
                cnt_next     = cnt_reg + 6'd1;
                if (cnt_reg == MD_LAST_ITER) begin
                    state_next = MD_FIX;
                end
            end

            MD_FIX: begin
                if (is_div_reg) begin
                    hi_next = rem_fixed;
                    lo_next = quot_fixed;
                end else begin
                    hi_next = product_fixed[63:32];
                    lo_next = product_fixed[31:0];
                end
                state_next = MD_IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end

            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= MD_IDLE;
            cnt_reg     <= 6'd0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            oper_reg    <= 32'd0;
            work_hi_reg <= 32'd0;
            work_lo_reg <= 32'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            is_div_reg  <= is_div_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            oper_reg    <= oper_next;
            work_hi_reg <= work_hi_next;
            work_lo_reg <= work_lo_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign md.busy = busy_reg;
    assign md.done = done_reg;
    assign md.hi   = hi_reg;
    assign md.lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed and randomized checks of mult_div_unit against an arithmetic
// reference model (64-bit integer multiply/divide with the divide-by-zero
// results defined for this unit). One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic reset;

    mult_div_unit_if md_if();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model of the architectural HI/LO registers
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} for a multiply/divide request.
    function automatic logic [63:0] ref_result(input funct_t fn, input logic [31:0] av,
                                               input logic [31:0] bv);
        longint sa, sb, q, r;
        logic [63:0] res;
        res = 64'd0;
        sa  = $signed(av);
        sb  = $signed(bv);
        case (fn)
            FUNCT_MULTU: res = {32'd0, av} * {32'd0, bv};
            FUNCT_MULT:  res = 64'(sa * sb);
            FUNCT_DIVU: begin
                if (bv == 32'd0) res = {av, 32'hFFFF_FFFF};
                else             res = {av % bv, av / bv};
            end
            FUNCT_DIV: begin
                if (bv == 32'd0) begin
                    // raw q = all ones, raw rem = |a|, both sign-corrected by a[31]
                    res = {av, (av[31] ? 32'd1 : 32'hFFFF_FFFF)};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = {m_hi, m_lo};
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Single-edge request (MTHI/MTLO/ignored funct). Called at a negedge;
    // returns at the following negedge.
    task automatic run_short(input string tag, input funct_t fn, input logic [31:0] av);
        md_if.start  = 1'b1;
        md_if.fncode = fn;
        md_if.a      = av;
        md_if.b      = $urandom;
        @(negedge clk);
        md_if.start = 1'b0;
        if (fn == FUNCT_MTHI) m_hi = av;
        if (fn == FUNCT_MTLO) m_lo = av;
        $display("%s: fn=%02h a=%08h -> hi=%08h lo=%08h busy=%0b", tag, fn, av,
                 md_if.hi, md_if.lo, md_if.busy);
        check({tag, "_busy"}, 64'(md_if.busy), 64'd0);
        check({tag, "_done"}, 64'(md_if.done), 64'd0);
        check({tag, "_hi"},   64'(md_if.hi),   64'(m_hi));
        check({tag, "_lo"},   64'(md_if.lo),   64'(m_lo));
    endtask

    // Multiply/divide request. Called at a negedge; returns at the negedge
    // after the done pulse has fallen.
    task automatic run_long(input string tag, input funct_t fn, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] ehi,
                            input logic [31:0] elo);
        int cycles;
        bit held;
        md_if.start  = 1'b1;
        md_if.fncode = fn;
        md_if.a      = av;
        md_if.b      = bv;
        @(negedge clk);
        md_if.start = 1'b0;
        check({tag, "_busy"}, 64'(md_if.busy), 64'd1);
        cycles = 0;
        held   = 1'b1;
        while (md_if.busy && cycles < 100) begin
            if (md_if.hi !== m_hi || md_if.lo !== m_lo || md_if.done !== 1'b0) held = 1'b0;
            cycles++;
            @(negedge clk);
        end
        $display("%s: fn=%02h a=%08h b=%08h -> hi=%08h lo=%08h cycles=%0d", tag, fn, av, bv,
                 md_if.hi, md_if.lo, cycles);
        check({tag, "_cycles"}, 64'(cycles), 64'd33);
        check({tag, "_hold"},   64'(held),   64'd1);
        check({tag, "_done"},   64'(md_if.done), 64'd1);
        check({tag, "_hi"},     64'(md_if.hi),   64'(ehi));
        check({tag, "_lo"},     64'(md_if.lo),   64'(elo));
        m_hi = ehi;
        m_lo = elo;
        @(negedge clk);
        check({tag, "_done_fall"}, 64'(md_if.done), 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        funct_t      fn;
        logic [31:0] ra, rb;
        int          cycles;

        reset        = 1'b1;
        md_if.start  = 1'b0;
        md_if.fncode = 6'h00;
        md_if.a      = 32'd0;
        md_if.b      = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(md_if.busy), 64'd0);
        check("rst_done", 64'(md_if.done), 64'd0);
        check("rst_hi",   64'(md_if.hi),   64'd0);
        check("rst_lo",   64'(md_if.lo),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases
        run_long("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_long("mult_neg",  FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_long("div_neg",   FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_long("divu_zero", FUNCT_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        run_long("div_ovf",   FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Back-to-back MTHI / MTLO
        run_short("mthi", FUNCT_MTHI, 32'h1234_5678);
        run_short("mtlo", FUNCT_MTLO, 32'h9ABC_DEF0);

        // Request held through busy: second MULTU is taken on the done cycle
        md_if.start  = 1'b1;
        md_if.fncode = FUNCT_MULTU;
        md_if.a      = 32'd3;
        md_if.b      = 32'd5;
        @(negedge clk);
        md_if.a = 32'd2;
        md_if.b = 32'd2;
        check("hold_busy", 64'(md_if.busy), 64'd1);
        cycles = 0;
        while (md_if.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        $display("hold_first: hi=%08h lo=%08h cycles=%0d", md_if.hi, md_if.lo, cycles);
        check("hold_cycles1", 64'(cycles),       64'd33);
        check("hold_done1",   64'(md_if.done),   64'd1);
        check("hold_hi1",     64'(md_if.hi),     64'd0);
        check("hold_lo1",     64'(md_if.lo),     64'd15);
        @(negedge clk);
        md_if.start = 1'b0;
        check("hold_accept",    64'(md_if.busy), 64'd1);
        check("hold_done_fall", 64'(md_if.done), 64'd0);
        check("hold_lo_keep",   64'(md_if.lo),   64'd15);
        cycles = 0;
        while (md_if.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        $display("hold_second: hi=%08h lo=%08h cycles=%0d", md_if.hi, md_if.lo, cycles);
        check("hold_cycles2", 64'(cycles),     64'd33);
        check("hold_done2",   64'(md_if.done), 64'd1);
        check("hold_hi2",     64'(md_if.hi),   64'd0);
        check("hold_lo2",     64'(md_if.lo),   64'd4);
        m_hi = 32'd0;
        m_lo = 32'd4;
        @(negedge clk);

        // Reset in the middle of a DIVU
        run_short("mthi_pre_rst", FUNCT_MTHI, 32'hDEAD_BEEF);
        md_if.start  = 1'b1;
        md_if.fncode = FUNCT_DIVU;
        md_if.a      = $urandom;
        md_if.b      = 32'($urandom_range(1, 1000));
        @(negedge clk);
        md_if.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        $display("reset_mid_div: busy=%0b hi=%08h lo=%08h", md_if.busy, md_if.hi, md_if.lo);
        check("midrst_busy", 64'(md_if.busy), 64'd0);
        check("midrst_done", 64'(md_if.done), 64'd0);
        check("midrst_hi",   64'(md_if.hi),   64'd0);
        check("midrst_lo",   64'(md_if.lo),   64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        run_long("mul_6x7", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        // Randomized mix against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0:       fn = FUNCT_MULT;
                1:       fn = FUNCT_MULTU;
                2:       fn = FUNCT_DIV;
                3:       fn = FUNCT_DIVU;
                4:       fn = FUNCT_MTHI;
                5:       fn = FUNCT_MTLO;
                default: fn = ($urandom_range(0, 1) == 0) ? FUNCT_MFHI : 6'h20;
            endcase
            ra = pick_operand();
            rb = pick_operand();
            if (fn == FUNCT_MULT || fn == FUNCT_MULTU || fn == FUNCT_DIV || fn == FUNCT_DIVU) begin
                r = ref_result(fn, ra, rb);
                run_long($sformatf("rnd%0d", i), fn, ra, rb, r[63:32], r[31:0]);
            end else begin
                run_short($sformatf("rnd%0d", i), fn, ra);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle sequencer for the MIPS HI/LO operations (MULT, MULTU, DIV, DIVU, MTHI, MTLO) alongside the single-cycle ALU. The block accepts an operation from the execute stage and iterates a shift-add or shift-subtract datapath one bit per cycle. It holds the architectural HI/LO registers. It raises `busy` so the core stalls MFHI/MFLO and any further HI/LO operation until the result is committed.

## Interface
- Parameters: none. Width is fixed at 32 by the ISA.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe, sampled on a clk edge when `busy`=0.
- fncode  in  funct_t  R-type funct field of the requesting instruction.
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  32  rt operand (divisor / multiplier).
- busy  out  1  operation in flight; the core must stall HI/LO consumers.
- done  out  1  one-cycle pulse: `hi`/`lo` have just been updated by MULT/DIV.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: 32 multiply iterations.
  - DIV: 32 divide iterations.
  - FIX: sign correction and HI/LO commit.
- IDLE, start=1:
  - FUNCT_MULT / FUNCT_MULTU goes to MUL.
  - FUNCT_DIV / FUNCT_DIVU goes to DIV.
  - FUNCT_MTHI writes hi=a and stays IDLE.
  - FUNCT_MTLO writes lo=a and stays IDLE.
  - Any other fncode is ignored.
- On entry to MUL or DIV:
  - Latch a signed flag: DIV or MULT is signed; MULTU and DIVU are unsigned.
  - Latch operand magnitudes. Signed negatives are two's-complement negated. |0x80000000| = 0x80000000 as unsigned.
  - Latch the result sign. For MULT and for the DIV quotient it is a[31]^b[31]. For the DIV remainder it is a[31]. All sign flags are 0 when unsigned.
  - Clear the 6-bit iteration counter.
- MUL iteration:
  - 64-bit accumulator {acc_hi, acc_lo}, acc_lo initialised to the multiplier.
  - Each cycle: if acc_lo[0], acc_hi += multiplicand with a 33-bit carry; then shift the 65-bit value right by 1.
- DIV iteration, restoring:
  - Remainder register rem (33 bit), quotient register q (32 bit), q initialised to the dividend.
  - Each cycle: shift {rem,q} left 1 and trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set q[0]=1. Otherwise restore rem and set q[0]=0.
- After counter = 31, go to FIX.
- FIX:
  - MUL writes {hi,lo} = 64-bit product, negated as 64-bit if the sign flag is set.
  - DIV writes lo = quotient and hi = remainder, each negated by its own sign flag.
  - Then go to IDLE.
- Divide by zero, all 33 cycles still taken:
  - Unsigned: the algorithm naturally yields lo=0xFFFFFFFF, hi=a. This is required.
  - Signed: the same raw values are sign-corrected per the rules above. No trap.
- 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0x00000000.
- start with a HI/LO fncode while busy=1 is ignored, with no state change. The core guarantees stall, so no queueing is required.

## Timing
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately and discards the partial result.
- MTHI/MTLO: hi/lo update at the sampling edge. busy stays 0 and done stays 0.
- MULT/DIV: start is sampled at edge E0.
  - busy=1 after E0 through E33, i.e. 33 cycles.
  - Iterations occur at E1..E32.
  - FIX commits hi/lo at E33. After E33, busy=0 and done=1 for exactly one cycle.
- hi/lo hold their previous values throughout MUL/DIV. Only FIX, MTHI or MTLO change them.
- busy and done are registered (no combinational path from start). hi/lo are register outputs.
- A start may be sampled in the same cycle that done=1 (busy=0 then). The new operation begins and done deasserts normally.

## Structure
- Add to the shared package:
  - FUNCT_MULT=6'h18, FUNCT_MULTU=6'h19, FUNCT_DIV=6'h1A, FUNCT_DIVU=6'h1B.
  - FUNCT_MFHI=6'h10, FUNCT_MTHI=6'h11, FUNCT_MFLO=6'h12, FUNCT_MTLO=6'h13. These extend funct_t.
  - An md_state_t enum {MD_IDLE, MD_MUL, MD_DIV, MD_FIX}.
- Single module. The MUL and DIV iteration logic is small enough to live inline. No sub-module.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 33 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo update at each edge, busy never asserts. Issue MULTU 3×5 and hold start with a second MULTU 2×2 during busy -> the second request is ignored while busy and accepted on the done cycle. Final hi=0, lo=4, with the intermediate lo=15 visible while done=1.
- Assert reset at iteration 10 of DIVU -> busy=0, hi=lo=0 immediately. A following MULTU 6×7 completes normally with lo=42.
